// File: rtl/rvsteel_uart_bridge_pkg.sv
// Shared constants and command-FSM encoding for the UART-to-bus bridge.
package rvsteel_uart_bridge_pkg;

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_BUS_REQ,
        S_BUS_WAIT,
        S_SEND_DATA,
        S_SEND_ACK
    } state_t;

endpackage

// File: rtl/rvsteel_uart_bridge_phy.sv
// Byte-level 8N1 serialiser: RX bytes out as valid/error pulses, TX bytes in via start/ready.
// RX bits last CYCLES_PER_BAUD cycles; TX bits last CYCLES_PER_BAUD+1 cycles.
module rvsteel_uart_bridge_phy #(
    parameter int CYCLES_PER_BAUD = 16
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic       o_tx,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_frame_error,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_idle
);

    localparam int CW = $clog2(CYCLES_PER_BAUD + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t       r_rx_state, w_rx_next;
    logic [2:0]      r_rx_sync;
    logic [CW-1:0]   r_rx_cnt;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;
    logic            r_rx_valid, r_rx_error;
    logic            w_rx, w_half, w_full;

    assign w_rx   = r_rx_sync[1];
    assign w_half = (r_rx_cnt == CW'(CYCLES_PER_BAUD / 2));
    assign w_full = (r_rx_cnt == CW'(CYCLES_PER_BAUD - 1));

    // Only a falling edge starts a byte, so a line held low after a bad stop bit is ignored.
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_sync[2] && !w_rx) w_rx_next = RX_START;
            RX_START: if (w_half) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_full && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_full) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_sync  <= 3'b111;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
            r_rx_error <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            r_rx_sync  <= {r_rx_sync[1:0], i_rx};
            if (r_rx_state == RX_IDLE || (r_rx_state == RX_START && w_half) || w_full)
                r_rx_cnt <= '0;
            else
                r_rx_cnt <= r_rx_cnt + 1'b1;
            if (r_rx_state == RX_DATA && w_full) begin
                r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
            r_rx_valid <= (r_rx_state == RX_STOP) && w_full && w_rx;
            r_rx_error <= (r_rx_state == RX_STOP) && w_full && !w_rx;
        end
    end

    assign o_rx_valid       = r_rx_valid;
    assign o_rx_byte        = r_rx_shift;
    assign o_rx_frame_error = r_rx_error;

    logic [9:0]    r_tx_shift;
    logic [3:0]    r_tx_bits;
    logic [CW-1:0] r_tx_cnt;
    logic          w_tx_last;

    assign w_tx_last  = (r_tx_cnt == CW'(CYCLES_PER_BAUD));
    assign o_tx_idle  = (r_tx_bits == 4'd0);
    // Ready in the final stop-bit cycle too, so the next start bit follows with no gap.
    assign o_tx_ready = o_tx_idle || (r_tx_bits == 4'd1 && w_tx_last);
    assign o_tx       = r_tx_shift[0];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tx_shift <= '1;
            r_tx_bits  <= '0;
            r_tx_cnt   <= '0;
        end else if (i_tx_start && o_tx_ready) begin
            r_tx_shift <= {1'b1, i_tx_byte, 1'b0};
            r_tx_bits  <= 4'd10;
            r_tx_cnt   <= '0;
        end else if (!o_tx_idle) begin
            if (w_tx_last) begin
                r_tx_cnt   <= '0;
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                r_tx_bits  <= r_tx_bits - 4'd1;
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvsteel_uart_bridge.sv
// UART command FSM and bus initiator. Optional bus timeout under RVSTEEL_UART_BRIDGE_TIMEOUT_EN
// (NAK reply after BUS_TIMEOUT silent BUS_WAIT cycles); without it BUS_WAIT waits forever.
module rvsteel_uart_bridge
    import rvsteel_uart_bridge_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UART_BAUD_RATE  = 9600,
    parameter int BUS_TIMEOUT     = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    output logic [31:0] o_rw_address,
    input  logic [31:0] i_read_data,
    output logic        o_read_request,
    input  logic        i_read_response,
    output logic [31:0] o_write_data,
    output logic [3:0]  o_write_strobe,
    output logic        o_write_request,
    input  logic        i_write_response,
    output logic        o_busy
);

    localparam int CYCLES_PER_BAUD = CLOCK_FREQUENCY / UART_BAUD_RATE;

    state_t      r_state, w_next;
    logic [1:0]  r_cnt;
    logic        r_is_write;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic        w_rx_valid, w_rx_error, w_tx_start, w_tx_ready, w_tx_idle;
    logic [7:0]  w_rx_byte, w_tx_byte;
    logic        w_req, w_resp, w_timeout;

    rvsteel_uart_bridge_phy #(.CYCLES_PER_BAUD(CYCLES_PER_BAUD)) u_phy (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_rx             (i_uart_rx),
        .o_tx             (o_uart_tx),
        .o_rx_valid       (w_rx_valid),
        .o_rx_byte        (w_rx_byte),
        .o_rx_frame_error (w_rx_error),
        .i_tx_start       (w_tx_start),
        .i_tx_byte        (w_tx_byte),
        .o_tx_ready       (w_tx_ready),
        .o_tx_idle        (w_tx_idle)
    );

`ifdef RVSTEEL_UART_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(BUS_TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset || r_state != S_BUS_WAIT) r_to_cnt <= '0;
        else                                  r_to_cnt <= r_to_cnt + 1'b1;
    end
    assign w_timeout = (r_state == S_BUS_WAIT) && (r_to_cnt == TO_W'(BUS_TIMEOUT - 1));
`else
    // Never times out.
    assign w_timeout = (BUS_TIMEOUT < 0);
`endif

    assign w_req  = (r_state == S_BUS_REQ) || (r_state == S_BUS_WAIT);
    assign w_resp = r_is_write ? i_write_response : i_read_response;

    // Replies that start on a state change are handed to the TX while it is known idle.
    always_comb begin
        w_next     = r_state;
        w_tx_start = 1'b0;
        w_tx_byte  = NAK;
        case (r_state)
            S_IDLE: if (w_rx_valid) begin
                if (w_rx_byte == OP_READ || w_rx_byte == OP_WRITE) begin
                    w_next = S_GET_ADDR;
                end else begin
                    w_tx_start = 1'b1;
                    w_next     = S_SEND_ACK;
                end
            end
            S_GET_ADDR: begin
                if (w_rx_error) w_next = S_IDLE;
                else if (w_rx_valid && r_cnt == 2'd3) w_next = r_is_write ? S_GET_DATA : S_BUS_REQ;
            end
            S_GET_DATA: begin
                if (w_rx_error) w_next = S_IDLE;
                else if (w_rx_valid && r_cnt == 2'd3) w_next = S_BUS_REQ;
            end
            S_BUS_REQ, S_BUS_WAIT: begin
                if (w_resp) begin
                    w_tx_start = 1'b1;
                    w_tx_byte  = r_is_write ? ACK : i_read_data[7:0];
                    w_next     = r_is_write ? S_SEND_ACK : S_SEND_DATA;
                end else if (w_timeout) begin
                    w_tx_start = 1'b1;
                    w_next     = S_SEND_ACK;
                end else begin
                    w_next = S_BUS_WAIT;
                end
            end
            S_SEND_DATA: if (w_tx_ready) begin
                w_tx_start = 1'b1;
                w_tx_byte  = r_rdata[{r_cnt, 3'b000} +: 8];
                if (r_cnt == 2'd3) w_next = S_SEND_ACK;
            end
            // Also drains the final byte of every reply before going idle.
            S_SEND_ACK: if (w_tx_idle) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_next == S_GET_ADDR) begin
                        r_is_write <= (w_rx_byte == OP_WRITE);
                        r_addr     <= '0;
                        r_wdata    <= '0;
                    end
                end
                S_GET_ADDR: if (w_rx_valid) begin
                    r_addr <= {w_rx_byte, r_addr[31:8]};
                    r_cnt  <= r_cnt + 2'd1;
                end
                S_GET_DATA: if (w_rx_valid) begin
                    r_wdata <= {w_rx_byte, r_wdata[31:8]};
                    r_cnt   <= r_cnt + 2'd1;
                end
                S_BUS_REQ, S_BUS_WAIT: if (w_resp) begin
                    r_cnt <= 2'd1;
                    if (!r_is_write) r_rdata <= i_read_data;
                end
                S_SEND_DATA: if (w_tx_start) r_cnt <= r_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    assign o_rw_address    = r_addr;
    assign o_write_data    = r_wdata;
    assign o_read_request  = w_req & ~r_is_write;
    assign o_write_request = w_req & r_is_write;
    assign o_write_strobe  = {4{o_write_request}};
    assign o_busy          = (r_state != S_IDLE);

endmodule
